// File: rtl/misr_pkg.sv
// Shared types and step/compaction functions for the logic-BIST controller.
// Functions work on a wide word and take the active width as an argument.
package misr_pkg;

  localparam int unsigned MaxLen = 64;

  typedef logic [MaxLen-1:0] word_t;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StCmp,
    StDone
  } bist_state_t;

  function automatic word_t len_mask(input int unsigned len);
    return (len >= MaxLen) ? '1 : ((word_t'(1) << len) - word_t'(1));
  endfunction

  function automatic logic parity(input word_t vec, input word_t mask);
    return ^(vec & mask);
  endfunction

  // Rotate left within the low len bits.
  function automatic word_t rotl(input word_t vec, input int unsigned n, input int unsigned len);
    word_t       v;
    int unsigned k;
    v = vec & len_mask(len);
    k = n % len;
    if (k == 0) return v;
    return ((v << k) | (v >> (len - k))) & len_mask(len);
  endfunction

  function automatic word_t lfsr_step(input word_t s, input word_t poly, input int unsigned len);
    return ((s << 1) | word_t'(parity(s & len_mask(len), poly))) & len_mask(len);
  endfunction

  function automatic word_t misr_step(input word_t s, input word_t poly, input word_t fold,
                                     input int unsigned len);
    return lfsr_step(s, poly, len) ^ (fold & len_mask(len));
  endfunction

endpackage

// File: rtl/bist_lfsr_gen.sv
// Pattern LFSR with synchronous load of the seed and step enable.
module bist_lfsr_gen
  import misr_pkg::*;
#(
  parameter int unsigned            LFSR_LENGTH    = 16,
  parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 16'b1011_0100_0000_0001,
  parameter logic [LFSR_LENGTH-1:0] LFSR_SEED_VAL  = 16'b1011_0101_1101_1010
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic                   i_en,
  output logic [LFSR_LENGTH-1:0] o_state
);

  logic [LFSR_LENGTH-1:0] r_state;
  logic [LFSR_LENGTH-1:0] w_next;

  assign w_next = LFSR_LENGTH'(lfsr_step(word_t'(r_state), word_t'(LFSR_PRIM_POLY), LFSR_LENGTH));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_load) begin
      r_state <= LFSR_SEED_VAL;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/misr_bist_ctrl.sv
// Logic-BIST controller: pattern LFSR, multi-channel MISR with latency-aligned
// enable, and a run/drain/compare sequencer reporting pass/fail.
module misr_bist_ctrl
  import misr_pkg::*;
#(
  parameter int unsigned            LFSR_LENGTH    = 16,
  parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 16'b1011_0100_0000_0001,
  parameter logic [LFSR_LENGTH-1:0] LFSR_SEED_VAL  = 16'b1011_0101_1101_1010,
  parameter logic [LFSR_LENGTH-1:0] MISR_SEED_VAL  = 16'b0101_0101_1101_1110,
  parameter int unsigned            NUM_CH         = 2,
  parameter int unsigned            RESP_LAT       = 1,
  parameter int unsigned            CNT_WIDTH      = 16
) (
  input  logic                          lfsr_clk,
  input  logic                          resetn,
  input  logic                          bist_start,
  input  logic                          bist_abort,
  input  logic [CNT_WIDTH-1:0]          pat_count,
  input  logic [LFSR_LENGTH-1:0]        golden_sig,
  input  logic [NUM_CH*LFSR_LENGTH-1:0] resp_in,
  output logic [LFSR_LENGTH-1:0]        pat_out,
  output logic                          pat_valid,
  output logic [LFSR_LENGTH-1:0]        misr_state_out,
  output logic                          bist_busy,
  output logic                          bist_done,
  output logic                          bist_pass
);

  if (LFSR_SEED_VAL == '0) begin : g_bad_seed
    $error("LFSR_SEED_VAL must be nonzero");
  end
  if (LFSR_LENGTH < 3 || LFSR_LENGTH > MaxLen) begin : g_bad_len
    $error("LFSR_LENGTH out of range");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("NUM_CH must be 1..8");
  end
  if (RESP_LAT > 4) begin : g_bad_lat
    $error("RESP_LAT must be 0..4");
  end

  localparam bist_state_t StAfterRun = (RESP_LAT == 0) ? StCmp : StDrain;
  localparam logic [2:0]  DrainLoad  = 3'(RESP_LAT);

  bist_state_t            r_state;
  bist_state_t            w_state_d;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [2:0]             r_drain;
  logic [LFSR_LENGTH-1:0] r_misr;
  logic [LFSR_LENGTH-1:0] w_misr_next;
  logic                   r_pass;
  logic                   w_start_ok;
  logic                   w_pat_valid;
  logic                   w_misr_en;
  logic                   w_lfsr_en;

  bist_lfsr_gen #(
    .LFSR_LENGTH   (LFSR_LENGTH),
    .LFSR_PRIM_POLY(LFSR_PRIM_POLY),
    .LFSR_SEED_VAL (LFSR_SEED_VAL)
  ) u_lfsr (
    .i_clk  (lfsr_clk),
    .i_rst_n(resetn),
    .i_load (w_start_ok),
    .i_en   (w_lfsr_en),
    .o_state(pat_out)
  );

  always_ff @(posedge lfsr_clk) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_start_ok = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (bist_start) begin
          w_start_ok = 1'b1;
          w_state_d  = (pat_count == '0) ? StAfterRun : StRun;
        end
      end
      StRun:   if (r_cnt == CNT_WIDTH'(1)) w_state_d = StAfterRun;
      StDrain: if (r_drain == 3'd1) w_state_d = StCmp;
      StCmp:   w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
    if (bist_abort) begin
      w_state_d  = StIdle;
      w_start_ok = 1'b0;
    end
    w_pat_valid = (r_state == StRun);
    bist_busy   = (r_state == StRun) || (r_state == StDrain) || (r_state == StCmp);
    bist_done   = (r_state == StDone);
    w_lfsr_en   = w_pat_valid && !bist_abort;
  end

  // Enable the MISR when the response to a live pattern arrives.
  if (RESP_LAT == 0) begin : g_no_pipe
    assign w_misr_en = w_pat_valid;
  end else begin : g_pipe
    logic [RESP_LAT-1:0] r_pipe;
    always_ff @(posedge lfsr_clk) begin
      if (!resetn || bist_abort) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= (r_pipe << 1) | RESP_LAT'(w_pat_valid);
      end
    end
    assign w_misr_en = r_pipe[RESP_LAT-1];
  end

  // Channel c is rotated by c so identical channels do not cancel.
  always_comb begin
    word_t v_fold;
    v_fold = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      v_fold ^= rotl(word_t'(resp_in[c*LFSR_LENGTH +: LFSR_LENGTH]), c, LFSR_LENGTH);
    end
    w_misr_next = LFSR_LENGTH'(misr_step(word_t'(r_misr), word_t'(LFSR_PRIM_POLY), v_fold,
                                         LFSR_LENGTH));
  end

  always_ff @(posedge lfsr_clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_drain <= '0;
      r_misr  <= MISR_SEED_VAL;
      r_pass  <= 1'b0;
    end else begin
      if (w_state_d == StDrain && r_state != StDrain) begin
        r_drain <= DrainLoad;
      end else if (r_state == StDrain) begin
        r_drain <= r_drain - 3'd1;
      end
      if (bist_abort) begin
        r_pass <= 1'b0;
      end else if (w_start_ok) begin
        r_cnt  <= pat_count;
        r_misr <= MISR_SEED_VAL;
        r_pass <= 1'b0;
      end else begin
        if (r_state == StRun) r_cnt <= r_cnt - CNT_WIDTH'(1);
        if (w_misr_en) r_misr <= w_misr_next;
        if (r_state == StCmp) r_pass <= (r_misr == golden_sig);
      end
    end
  end

  assign pat_valid      = w_pat_valid;
  assign misr_state_out = r_misr;
  assign bist_pass      = r_pass;

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Bench for misr_bist_ctrl: two configurations, a directed vector table,
// randomized runs against a signature model, and abort/reset sequences.
module tb_misr_bist_ctrl;

  logic        clk;
  logic        resetn;
  logic        bist_start;
  logic        bist_abort;
  logic [7:0]  pat_count;
  logic [15:0] golden;
  logic [47:0] resp_w;
  int          sel;

  logic        start_a, start_b, abort_a, abort_b;
  logic [3:0]  po_a, misr_a;
  logic [15:0] po_b, misr_b;
  logic        pv_a, busy_a, done_a, pass_a, pv_b, busy_b, done_b, pass_b;

  logic [15:0] o_po, o_misr;
  logic        o_pv, o_busy, o_done, o_pass;

  int n_checks = 0;
  int n_fail   = 0;

  int          cfg_len [2] = '{4, 16};
  int          cfg_lat [2] = '{0, 3};
  int          cfg_nch [2] = '{2, 3};
  logic [15:0] cfg_poly[2] = '{16'h000D, 16'hB401};
  logic [15:0] cfg_ls  [2] = '{16'h000D, 16'hB5DA};
  logic [15:0] cfg_ms  [2] = '{16'h0005, 16'h55DE};

  logic [47:0] resp_hist[64];
  logic [15:0] model_pat[64];
  logic [15:0] obs_pat  [64];
  logic [15:0] last_sig;
  logic        last_pass;
  int          last_done;

  assign start_a = bist_start && (sel == 0);
  assign start_b = bist_start && (sel == 1);
  assign abort_a = bist_abort && (sel == 0);
  assign abort_b = bist_abort && (sel == 1);

  misr_bist_ctrl #(
    .LFSR_LENGTH(4), .LFSR_PRIM_POLY(4'b1101), .LFSR_SEED_VAL(4'b1101),
    .MISR_SEED_VAL(4'b0101), .NUM_CH(2), .RESP_LAT(0), .CNT_WIDTH(8)
  ) u_dut_a (
    .lfsr_clk(clk), .resetn(resetn), .bist_start(start_a), .bist_abort(abort_a),
    .pat_count(pat_count), .golden_sig(golden[3:0]), .resp_in(resp_w[7:0]),
    .pat_out(po_a), .pat_valid(pv_a), .misr_state_out(misr_a), .bist_busy(busy_a),
    .bist_done(done_a), .bist_pass(pass_a)
  );

  misr_bist_ctrl #(
    .LFSR_LENGTH(16), .LFSR_PRIM_POLY(16'hB401), .LFSR_SEED_VAL(16'hB5DA),
    .MISR_SEED_VAL(16'h55DE), .NUM_CH(3), .RESP_LAT(3), .CNT_WIDTH(8)
  ) u_dut_b (
    .lfsr_clk(clk), .resetn(resetn), .bist_start(start_b), .bist_abort(abort_b),
    .pat_count(pat_count), .golden_sig(golden), .resp_in(resp_w),
    .pat_out(po_b), .pat_valid(pv_b), .misr_state_out(misr_b), .bist_busy(busy_b),
    .bist_done(done_b), .bist_pass(pass_b)
  );

  always_comb begin
    if (sel == 0) begin
      o_po = 16'(po_a); o_misr = 16'(misr_a); o_pv = pv_a;
      o_busy = busy_a; o_done = done_a; o_pass = pass_a;
    end else begin
      o_po = po_b; o_misr = misr_b; o_pv = pv_b;
      o_busy = busy_b; o_done = done_b; o_pass = pass_b;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] msk(input int len);
    return 16'((32'd1 << len) - 32'd1);
  endfunction

  function automatic logic [15:0] m_step(input logic [15:0] s, input logic [15:0] poly,
                                         input int len);
    int ones = 0;
    for (int i = 0; i < len; i++) if (s[i] && poly[i]) ones++;
    return 16'(((32'(s) << 1) | 32'(ones % 2))) & msk(len);
  endfunction

  function automatic logic [15:0] m_fold(input logic [47:0] r, input int len, input int nch);
    logic [31:0] w;
    logic [15:0] acc = '0;
    for (int c = 0; c < nch; c++) begin
      w   = 32'(16'(r >> (c * len)) & msk(len));
      acc = acc ^ (16'((w << c) | (w >> (len - c))) & msk(len));
    end
    return acc;
  endfunction

  // One complete run on DUT d; per-cycle checks plus final signature/pass/latency.
  task automatic run(input int d, input int n, input bit rnd, input logic [47:0] rconst,
                     input bit gmodel, input bit corrupt, input logic [15:0] gconst);
    int          len, lat, done_k;
    logic [15:0] s, m, g;
    len = cfg_len[d];
    lat = cfg_lat[d];
    for (int k = 0; k < 64; k++) resp_hist[k] = rnd ? 48'({$urandom(), $urandom()}) : rconst;
    s = cfg_ls[d];
    m = cfg_ms[d];
    for (int k = 0; k < n; k++) begin
      model_pat[k] = s;
      s = m_step(s, cfg_poly[d], len);
    end
    for (int k = lat; k < lat + n; k++) begin
      m = m_step(m, cfg_poly[d], len) ^ m_fold(resp_hist[k], len, cfg_nch[d]);
    end
    g = gmodel ? (m ^ 16'(corrupt)) : gconst;
    @(negedge clk);
    sel = d; bist_start = 1'b1; pat_count = 8'(n); golden = g;
    done_k = -1;
    for (int k = 0; k < n + lat + 8; k++) begin
      @(negedge clk);
      bist_start = (k == 1) && (n + lat >= 1);
      pat_count  = 8'($urandom);
      chk("pat_valid", 32'(o_pv), 32'(k < n));
      chk("busy", 32'(o_busy), 32'(k <= n + lat));
      if (k < n) begin
        obs_pat[k] = o_po;
        chk("pat_out", 32'(o_po), 32'(model_pat[k]));
      end
      resp_w = resp_hist[k];
      if (o_done) begin
        done_k = k;
        break;
      end
    end
    bist_start = 1'b0;
    chk("done_latency", 32'(done_k), 32'(n + lat + 1));
    chk("signature", 32'(o_misr), 32'(m));
    chk("pass", 32'(o_pass), 32'(g == m));
    last_sig  = o_misr;
    last_pass = o_pass;
    last_done = done_k;
  endtask

  typedef struct {
    int          d;
    int          n;
    logic [47:0] resp;
    logic [15:0] golden;
    logic [15:0] exp_sig;
    bit          exp_pass;
    int          exp_done;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] cap_po, cap_misr;
  logic [15:0] exp_pats[3];

  initial begin
    tbl[0] = '{0, 3, 48'h0,  16'hA, 16'hA,    1'b1, 4};
    tbl[1] = '{0, 2, 48'h0,  16'h5, 16'h5,    1'b1, 3};
    tbl[2] = '{0, 2, 48'h0,  16'h4, 16'h5,    1'b0, 3};
    tbl[3] = '{0, 1, 48'h11, 16'h9, 16'h9,    1'b1, 2};
    tbl[4] = '{0, 0, 48'h0,  16'h5, 16'h5,    1'b1, 1};
    tbl[5] = '{1, 4, 48'h0,  16'h5DE1, 16'h5DE1, 1'b1, 8};
    exp_pats = '{16'hD, 16'hB, 16'h6};

    resetn = 1'b0; bist_start = 1'b0; bist_abort = 1'b0;
    pat_count = '0; golden = '0; resp_w = '0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      chk("rst_pat", 32'(o_po), 32'(cfg_ls[d]));
      chk("rst_misr", 32'(o_misr), 32'(cfg_ms[d]));
      chk("rst_flags", {28'd0, o_pv, o_busy, o_done, o_pass}, 32'd0);
    end
    resetn = 1'b1;

    run(0, 3, 1'b0, 48'h0, 1'b0, 1'b0, 16'hA);
    for (int k = 0; k < 3; k++) chk("lfsr_seq", 32'(obs_pat[k]), 32'(exp_pats[k]));

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].d, tbl[i].n, 1'b0, tbl[i].resp, 1'b0, 1'b0, tbl[i].golden);
      chk("tbl_sig", 32'(last_sig), 32'(tbl[i].exp_sig));
      chk("tbl_pass", 32'(last_pass), 32'(tbl[i].exp_pass));
      chk("tbl_done", 32'(last_done), 32'(tbl[i].exp_done));
    end

    for (int i = 0; i < 24; i++) begin
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 11)), 1'b1, 48'h0, 1'b1,
          1'($urandom_range(0, 1)), 16'h0);
    end

    // Abort from DONE clears the flags but keeps the signature.
    run(1, 3, 1'b1, 48'h0, 1'b1, 1'b0, 16'h0);
    bist_abort = 1'b1;
    @(negedge clk);
    bist_abort = 1'b0;
    chk("abort_done_flags", {29'd0, o_busy, o_done, o_pass}, 32'd0);
    chk("abort_done_misr", 32'(o_misr), 32'(last_sig));

    // Abort mid-run while the MISR is compacting.
    bist_start = 1'b1; pat_count = 8'd10; sel = 1;
    @(negedge clk);
    bist_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_before_abort", 32'(o_pv), 32'd1);
    cap_po = o_po; cap_misr = o_misr; resp_w = 48'hFFFF_1234_5678;
    bist_abort = 1'b1;
    @(negedge clk);
    bist_abort = 1'b0;
    chk("abort_run_flags", {28'd0, o_pv, o_busy, o_done, o_pass}, 32'd0);
    chk("abort_lfsr_hold", 32'(o_po), 32'(cap_po));
    chk("abort_misr_hold", 32'(o_misr), 32'(cap_misr));
    repeat (4) @(negedge clk);
    chk("abort_stays_idle", {28'd0, o_pv, o_busy, o_done, o_misr != cap_misr}, 32'd0);

    // Reset while draining.
    bist_start = 1'b1; pat_count = 8'd2;
    @(negedge clk);
    bist_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("drain_state", {30'd0, o_pv, o_busy}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_drain_pat", 32'(o_po), 32'(cfg_ls[1]));
    chk("rst_drain_misr", 32'(o_misr), 32'(cfg_ms[1]));
    chk("rst_drain_flags", {28'd0, o_pv, o_busy, o_done, o_pass}, 32'd0);

    run(1, 4, 1'b0, 48'h0, 1'b0, 1'b0, 16'h5DE1);
    chk("fresh_golden", {15'd0, last_pass, last_sig}, {15'd0, 1'b1, 16'h5DE1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/misr_bist_ctrl.md
# misr_bist_ctrl

Parametrised logic-BIST controller combining a pattern LFSR, a multi-channel MISR and a run/compare state machine. It drives `pat_count` pseudo-random patterns into a circuit under test and compacts up to `NUM_CH` response words, arriving with a fixed pipeline latency, into one signature. It then compares that signature against a golden value and reports pass/fail. It supersedes the free-running lfsr/misr pair as the self-test block for datapath macros.

## Interface
- `LFSR_LENGTH`, 16: width of the LFSR, the MISR and each response channel (≥3).
- `LFSR_PRIM_POLY`, 16'b1011_0100_0000_0001: tap mask shared by the LFSR and the MISR.
- `LFSR_SEED_VAL`, 16'b1011_0101_1101_1010: pattern LFSR seed; must be nonzero (elaboration assertion).
- `MISR_SEED_VAL`, 16'b0101_0101_1101_1110: MISR seed.
- `NUM_CH`, 2: number of response channels (1..8).
- `RESP_LAT`, 1: cycles from `pat_out` to the matching `resp_in` (0..4).
- `CNT_WIDTH`, 16: width of the pattern counter.
- `lfsr_clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `bist_start` in 1: start request, honoured only in IDLE or DONE.
- `bist_abort` in 1: abort request; returns the block to IDLE.
- `pat_count` in CNT_WIDTH: number of patterns, sampled at start.
- `golden_sig` in LFSR_LENGTH: expected signature, sampled in CMP.
- `resp_in` in NUM_CH*LFSR_LENGTH: response from the circuit under test; channel c occupies `[c*LFSR_LENGTH +: LFSR_LENGTH]`.
- `pat_out` out LFSR_LENGTH: current LFSR state.
- `pat_valid` out 1: high while `pat_out` is a live pattern.
- `misr_state_out` out LFSR_LENGTH: current MISR state.
- `bist_busy`, `bist_done`, `bist_pass` out 1 each: status flags.

## Operation
- LFSR step: `next = {s[L-2:0], ^(s & LFSR_PRIM_POLY)}`.
- MISR step: `next = {m[L-2:0], ^(m & LFSR_PRIM_POLY)} ^ fold`.
- `fold` = XOR over c of `rotl(resp_c, c)`. The rotation keeps identical channels from cancelling each other.
- FSM states: IDLE, RUN, DRAIN, CMP, DONE.
- **IDLE/DONE + `bist_start`:**
  - LFSR is loaded with `LFSR_SEED_VAL` and MISR with `MISR_SEED_VAL`.
  - Counter is loaded with `pat_count`; `bist_done` and `bist_pass` are cleared.
  - Next state is RUN, or DRAIN if `pat_count`==0.
- **RUN:**
  - `pat_valid`=1; the LFSR steps every cycle and the counter decrements.
  - The edge at which counter==1 moves the FSM to DRAIN.
  - Exactly `pat_count` patterns are emitted.
- **MISR enable:** `pat_valid` delayed by RESP_LAT flops. With RESP_LAT=0, `resp_in` is sampled in the same cycle as `pat_out`.
- **DRAIN:** lasts RESP_LAT cycles (0 cycles means straight to CMP); the MISR keeps compacting the tail responses.
- **CMP:** one cycle; `bist_pass <= (misr == golden_sig)`; next state is DONE.
- **DONE:** `bist_done`=1; the MISR and `bist_pass` hold their values until the next start.
- **Priority:** `resetn` > `bist_abort` > `bist_start`.
  - Abort in any state: go to IDLE, clear `pat_valid`, `bist_done`, `bist_pass` and the delay pipe. LFSR and MISR hold their values.
  - `bist_start` in RUN, DRAIN or CMP is ignored.

## Timing
- **Reset values (next edge with `resetn`=0):**
  - LFSR=`LFSR_SEED_VAL`, MISR=`MISR_SEED_VAL`, state IDLE.
  - Counter 0, delay pipe 0.
  - `pat_valid`, `bist_busy`, `bist_done`, `bist_pass` all 0.
  - Applies mid-run as well.
- `bist_busy` = state in {RUN, DRAIN, CMP}. It rises the cycle after the start edge.
- **Latency:** `bist_done` rises `pat_count + RESP_LAT + 1` edges after the edge sampling `bist_start` (RESP_LAT + 1 when `pat_count`=0).
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- The counter is not reloaded while running; a change on `pat_count` mid-run has no effect.

## Structure
- Package `misr_pkg` holds:
  - `bist_state_t` enum;
  - `parity(vec, mask)` and `rotl(vec, n)` functions;
  - step functions shared by the LFSR and the MISR.
- One sub-module, `bist_lfsr_gen`: pattern LFSR with load and enable.
- The MISR, fold, counter, delay pipe and FSM live in `misr_bist_ctrl`.

## Test plan
- **LFSR convention** (L=4, poly 4'b1101, seed 4'b1101, `pat_count`=3): `pat_out` = 1101, 1011, 0110; then `pat_valid` drops.
- **Zero-input signature** (NUM_CH=1, RESP_LAT=0, `resp_in`=0, MISR seed 0101, `pat_count`=2, golden 0101):
  - MISR goes 1010 then 0101;
  - `bist_pass`=1 and `bist_done` rises 3 edges after start.
- **Fold** (NUM_CH=2, L=4, both channels 0001 for one pattern, `pat_count`=1, RESP_LAT=0, MISR seed 0000): signature = 0011.
- **Latency** (RESP_LAT=3, `pat_count`=4): the MISR updates on exactly 4 cycles, offset by 3; `bist_done` at edge 8.
- **Fail:** same as the zero-input signature case but golden 0100 → `bist_pass`=0, `bist_done`=1.
- **Abort/reset mid-run:**
  - abort in RUN → IDLE the next cycle with all flags 0;
  - `resetn`=0 in DRAIN → all reset values;
  - a fresh start reproduces the golden signature.
